write_once_ram: RTL and testbench

Parametrised write-once memory with a registered read path, per-address usage tracking and data-bit overlap tracking. Each address may be written exactly once between clears; rewrites are rejected and flagged, reads of never-written addresses return zero and are flagged, and the OR of all accepted write data is accumulated to detect bit overlap between entries. It serves as a checked storage element in the smtbmc examples: small enough for BMC, with sticky error flags that formal properties and simulation benches can observe directly.

---
 rtl/write_once_ram.sv | 130 +++++++++++++
 tb/tb_write_once_ram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_once_ram.sv
// write_once_ram: write-once storage with per-address usage, data-bit overlap tracking and sticky error flags.
// Read latency READ_LAT (1 or 2) cycles, fully pipelined; no backpressure, one read and one write accepted per cycle.
module write_once_ram #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  output logic [ADDR_W:0]   used_count,
  output logic              full,
  output logic [DATA_W-1:0] bits_or,
  output logic              err_rewrite,
  output logic              err_unwritten,
  output logic              err_overlap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  used_q, used_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] bits_q, bits_d;
  logic              err_rw_q, err_rw_d;
  logic              err_un_q, err_un_d;
  logic              err_ov_q, err_ov_d;

  // Read pipeline: valid, hit and data per stage; the last stage drives the outputs.
  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [READ_LAT-1:0] ph_q, ph_d;
  logic [DATA_W-1:0]   pd_q [READ_LAT];
  logic [DATA_W-1:0]   pd_d [READ_LAT];

  logic wr_used, wr_acc, rd_used;

  always_comb begin
    rd_used = used_q[rd_addr];
    pv_d    = '0;
    ph_d    = '0;
    for (int i = 0; i < READ_LAT; i++) pd_d[i] = '0;
    pv_d[0] = rd_en;
    ph_d[0] = rd_en && rd_used;
    pd_d[0] = (rd_en && rd_used) ? mem_q[rd_addr] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      ph_d[i] = ph_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_comb begin
    wr_used  = used_q[wr_addr];
    wr_acc   = wr_en && !wr_used && !clr;
    used_d   = used_q;
    count_d  = count_q;
    bits_d   = bits_q;
    err_rw_d = err_rw_q;
    err_un_d = err_un_q;
    err_ov_d = err_ov_q;
    if (clr) begin
      used_d   = '0;
      count_d  = '0;
      bits_d   = '0;
      err_rw_d = 1'b0;
      err_un_d = 1'b0;
      err_ov_d = 1'b0;
    end else begin
      if (wr_acc) begin
        used_d[wr_addr] = 1'b1;
        count_d         = count_q + CNT_ONE;
        bits_d          = bits_q | wr_data;
        if (|(wr_data & bits_q)) err_ov_d = 1'b1;
      end
      if (wr_en && wr_used) err_rw_d = 1'b1;
      // Miss flag rises together with the result entering the output stage.
      if (pv_d[READ_LAT-1] && !ph_d[READ_LAT-1]) err_un_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      used_q   <= '0;
      count_q  <= '0;
      bits_q   <= '0;
      err_rw_q <= 1'b0;
      err_un_q <= 1'b0;
      err_ov_q <= 1'b0;
      pv_q     <= '0;
      ph_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= '0;
    end else begin
      used_q   <= used_d;
      count_q  <= count_d;
      bits_q   <= bits_d;
      err_rw_q <= err_rw_d;
      err_un_q <= err_un_d;
      err_ov_q <= err_ov_d;
      pv_q     <= pv_d;
      ph_q     <= ph_d;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= pd_d[i];
    end
  end

  // Storage array is deliberately not reset; the used vector gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= wr_data;
  end

  assign rd_valid      = pv_q[READ_LAT-1];
  assign rd_hit        = ph_q[READ_LAT-1];
  assign rd_data       = pd_q[READ_LAT-1];
  assign used_count    = count_q;
  assign full          = (count_q == CNT_FULL);
  assign bits_or       = bits_q;
  assign err_rewrite   = err_rw_q;
  assign err_unwritten = err_un_q;
  assign err_overlap   = err_ov_q;

endmodule

// File: tb/tb_write_once_ram.sv
// Randomised scoreboard bench for write_once_ram: reference model of memory, used set and sticky flags.
module tb_write_once_ram;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_hit;
  logic [AW:0]   used_count;
  logic          full;
  logic [DW-1:0] bits_or;
  logic          err_rewrite;
  logic          err_unwritten;
  logic          err_overlap;

  write_once_ram #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit),
    .used_count(used_count), .full(full), .bits_or(bits_or),
    .err_rewrite(err_rewrite), .err_unwritten(err_unwritten), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    logic          hit;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: plain arrays, the used set and the sticky flags.
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_used = '0;
  logic [DW-1:0]    m_or = '0;
  logic             m_erw = 1'b0, m_eun = 1'b0, m_eov = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    m_used = '0;
    m_or   = '0;
    m_erw  = 1'b0;
    m_eun  = 1'b0;
    m_eov  = 1'b0;
  endfunction

  // Monitor: pops the scoreboard whenever a read result is presented.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got rd_valid=1 with data %0h expected no result", rd_data);
          end else begin
            e = exp_q.pop_front();
            chk("rd_hit", rd_hit, e.hit);
            chk("rd_data", rd_data, e.data);
            chk("rd_cycle", ecnt, e.due);
          end
        end else begin
          chk("rd_idle_zero", {rd_hit, rd_data}, '0);
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra, input logic cl);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = cl;
    if (re) begin
      e.hit  = m_used[ra];
      e.data = m_used[ra] ? m_mem[ra] : '0;
      e.due  = ecnt + LAT;
      exp_q.push_back(e);
      if (!m_used[ra]) m_eun = 1'b1;
    end
    if (cl) begin
      model_clear();
    end else if (we) begin
      if (m_used[wa]) begin
        m_erw = 1'b1;
      end else begin
        if ((wd & m_or) != '0) m_eov = 1'b1;
        m_mem[wa]  = wd;
        m_used[wa] = 1'b1;
        m_or       = m_or | wd;
      end
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".used_count"}, used_count, $countones(m_used));
    chk({tag, ".full"}, full, ($countones(m_used) == DEPTH));
    chk({tag, ".bits_or"}, bits_or, m_or);
    chk({tag, ".err_rewrite"}, err_rewrite, m_erw);
    chk({tag, ".err_unwritten"}, err_unwritten, m_eun);
    chk({tag, ".err_overlap"}, err_overlap, m_eov);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    if ($urandom_range(0, 3) != 0) d[$urandom_range(0, DW-1)] = 1'b1;
    return d;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [AW-1:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_valid", rd_valid, 1'b0);
    chk("reset.rd_outputs", {rd_hit, rd_data}, '0);
    check_state("reset");
    resetn = 1'b1;
    idle(1);

    // Read of an unwritten address.
    cyc(1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
    idle(LAT + 1);
    check_state("miss");
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(1);

    // Two disjoint writes read back.
    cyc(1'b1, 5'd5, 32'h1, 1'b0, '0, 1'b0);
    cyc(1'b1, 5'd6, 32'h2, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 5'd6, 1'b0);
    idle(LAT + 1);
    check_state("two_writes");
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(1);

    // Rewrite rejected, then overlapping write accepted.
    cyc(1'b1, 5'd7, 32'hA, 1'b0, '0, 1'b0);
    cyc(1'b1, 5'd7, 32'h5, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
    idle(LAT + 1);
    check_state("rewrite");
    cyc(1'b1, 5'd8, 32'h8, 1'b0, '0, 1'b0);
    idle(1);
    check_state("overlap");

    // Same-cycle read and write: read sees the old state.
    cyc(1'b1, 5'd9, 32'h10, 1'b1, 5'd9, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    idle(LAT + 1);
    check_state("rd_wr_same");

    // Fill every address, overflow write, then clear.
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, AW'(i), $urandom(), 1'b0, '0, 1'b0);
    idle(1);
    check_state("filled");
    cyc(1'b1, AW'($urandom_range(0, DEPTH-1)), $urandom(), 1'b0, '0, 1'b0);
    idle(1);
    check_state("full_write");
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check_state("cleared");
    cyc(1'b0, '0, '0, 1'b1, AW'($urandom_range(0, DEPTH-1)), 1'b0);
    idle(LAT + 1);
    check_state("clr_read");

    // Random traffic; clears are issued only after the read pipe drains.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        idle(LAT + 1);
        check_state("rand_pre_clr");
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
      end else begin
        a = AW'($urandom_range(0, DEPTH-1));
        cyc(1'(($urandom_range(0, 1))), a, rand_data(),
            1'(($urandom_range(0, 1))), AW'($urandom_range(0, DEPTH-1)), 1'b0);
      end
    end
    idle(LAT + 1);
    check_state("rand_end");

    // Reset while a read is in flight: its result must never appear.
    cyc(1'b1, 5'd3, 32'h55, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
    resetn = 1'b0;
    #2;
    exp_q.delete();
    model_clear();
    chk("async_rst.rd_valid", rd_valid, 1'b0);
    chk("async_rst.rd_outputs", {rd_hit, rd_data}, '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst.rd_valid", rd_valid, 1'b0);
      chk("post_rst.rd_outputs", {rd_hit, rd_data}, '0);
    end
    check_state("post_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
